// File: rtl/bin_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Default sizes cover the 13-bit accumulator feeding a 4-digit display.
package bin_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_ADJ_THR = 4'd5;
  localparam logic [DIGIT_W-1:0] BCD_ADJ_ADD = 4'd3;

  localparam int DEF_BIN_W  = 13;
  localparam int DEF_DIGITS = 4;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD nibble: values of 5 or more get +3
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adjust
  import bin_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  // A nibble of at most 9 plus 3 stays within 4 bits, so no inter-digit carry exists.
  assign o_digit = (i_digit >= BCD_ADJ_THR) ? i_digit + BCD_ADJ_ADD : i_digit;

endmodule

// File: rtl/bin_bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-add-3 iteration per clock.
// bcd_o holds the last complete result; at most one further request is queued.
module bin_bcd_seq
  import bin_bcd_pkg::*;
#(
  parameter int BIN_W      = DEF_BIN_W,
  parameter int DIGITS     = DEF_DIGITS,
  parameter bit AUTO_START = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [BIN_W-1:0]          bin_i,
  input  logic                      start_i,
  output logic [DIGIT_W*DIGITS-1:0] bcd_o,
  output logic                      done_o,
  output logic                      busy_o
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int SH_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(BIN_W - 1);

  state_t             r_state;
  logic [SH_W-1:0]    r_sh;
  logic [CNT_W-1:0]   r_cnt;
  logic [BIN_W-1:0]   r_last_bin;
  logic [BIN_W-1:0]   r_pend_val;
  logic               r_pend_flag;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_done;
  logic               r_busy;

  logic               w_req;
  logic [BIN_W-1:0]   w_load_val;
  logic [BCD_W-1:0]   w_bcd_adj;
  logic [SH_W-1:0]    w_sh_next;

  assign w_req      = AUTO_START ? (bin_i != r_last_bin) : start_i;
  // A fresh request in DONE supersedes anything already pending.
  assign w_load_val = w_req ? bin_i : r_pend_val;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit (r_sh[BIN_W + g*DIGIT_W +: DIGIT_W]),
      .o_digit (w_bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign w_sh_next = {w_bcd_adj, r_sh[BIN_W-1:0]} << 1;

  // NOTE: all state updates use <= so every register samples pre-edge values,
  // which keeps the shift, counter and pending logic order-independent.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_sh        <= '0;
      r_cnt       <= '0;
      r_last_bin  <= '0;
      r_pend_val  <= '0;
      r_pend_flag <= 1'b0;
      r_bcd       <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_sh       <= {{BCD_W{1'b0}}, bin_i};
            r_cnt      <= '0;
            r_last_bin <= bin_i;
            r_busy     <= 1'b1;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          r_sh  <= w_sh_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_IT) begin
            r_busy  <= 1'b0;
            r_state <= DONE;
          end
          if (w_req) begin
            r_pend_flag <= 1'b1;
            r_pend_val  <= bin_i;
            r_last_bin  <= bin_i;
          end
        end
        DONE: begin
          r_bcd       <= r_sh[SH_W-1 -: BCD_W];
          r_done      <= 1'b1;
          r_pend_flag <= 1'b0;
          if (w_req || r_pend_flag) begin
            r_sh       <= {{BCD_W{1'b0}}, w_load_val};
            r_cnt      <= '0;
            r_last_bin <= w_load_val;
            r_busy     <= 1'b1;
            r_state    <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bcd_o  = r_bcd;
  assign done_o = r_done;
  assign busy_o = r_busy;

endmodule

// File: doc/bin_bcd_seq.md
# bin_bcd_seq

Sequential binary-to-BCD converter (shift-add-3 / double-dabble) that sits between the accumulator stage (input_control) and the 7-segment scan driver (module_7_segments). It replaces the combinational bin_decimal path. It converts the 13-bit accumulator value into four packed BCD digits over BIN_W clock cycles. It holds the last valid result on its output so the display never shows a partial conversion.

## Interface
- BIN_W, 13: binary input width; must satisfy 2^BIN_W − 1 ≤ 10^DIGITS − 1.
- DIGITS, 4: number of BCD digits produced.
- AUTO_START, 1: 1 = start internally whenever bin_i differs from the last captured value; 0 = start only on start_i.
- clk_i  in  1  system clock. One clock.
- rst_i  in  1  reset, asynchronous, active-high.
- bin_i  in  BIN_W  binary value to convert (accumulator output).
- start_i  in  1  conversion request, sampled on rising edge; ignored when AUTO_START=1.
- bcd_o  out  4*DIGITS  packed BCD; digit 0 (units) in [3:0].
- done_o  out  1  one-cycle pulse when bcd_o is updated.
- busy_o  out  1  high while a conversion is in SHIFT.

## Operation
- Registers:
  - shift register {bcd_acc[4*DIGITS-1:0], bin_sh[BIN_W-1:0]}
  - iteration counter, width clog2(BIN_W+1)
  - last_bin: last captured value
  - pend_flag and pend_val
- Request: start_i=1 (AUTO_START=0), or bin_i ≠ last_bin (AUTO_START=1).
- IDLE:
  - On request: bin_sh ← bin_i, bcd_acc ← 0, last_bin ← bin_i, counter ← 0, go to SHIFT.
- SHIFT (one iteration per cycle):
  - Each nibble of bcd_acc that is ≥5 gets +3.
  - Then the concatenation shifts left 1.
  - Counter increments. After iteration BIN_W, go to DONE.
- DONE (exactly one cycle):
  - bcd_o ← bcd_acc, done_o=1.
  - If pend_flag: load pend_val as in IDLE, clear pend_flag, go to SHIFT.
  - Otherwise go to IDLE.
- Request arriving in SHIFT or DONE: pend_flag ← 1, pend_val ← bin_i, last_bin ← bin_i. The latest request overwrites earlier ones; at most one conversion is queued.
- A request in DONE while pend_flag is already set: the new value wins, and exactly one further conversion is queued.
- bcd_o changes only in DONE; between updates it holds the previous result.
- Arithmetic: add-3 is a 4-bit add per nibble. The ≥5 check keeps the result ≤ 0xC, so there is no carry between nibbles.
- Reset (any time, including mid-SHIFT):
  - State → IDLE.
  - bcd_o=0, done_o=0, busy_o=0.
  - Shift register, counter, pend_flag, pend_val and last_bin all cleared to 0.
  - With AUTO_START=1, a nonzero bin_i after reset triggers a conversion on the first edge.

## Timing
- Request sampled at edge k → BIN_W SHIFT cycles at edges k+1 … k+BIN_W → DONE entered at edge k+BIN_W.
- bcd_o and done_o become valid after edge k+BIN_W+1 (14 cycles for BIN_W=13).
- done_o is registered and lasts exactly one cycle.
- busy_o is registered: high after edge k through the last SHIFT cycle, low in DONE and IDLE.
- Back-to-back with pending: there is no IDLE bubble; the next conversion's first SHIFT follows DONE directly. Throughput is one result per BIN_W+1 cycles.
- Outputs do not depend combinationally on any input.

## Structure
- Shared package bin_bcd_pkg holds:
  - state enum IDLE/SHIFT/DONE
  - DIGIT_W=4, BCD_ADJ_THR=5, BCD_ADJ_ADD=3
  - the default BIN_W/DIGITS values used by the top.
- One sub-module, bcd_digit_adjust: combinational per-nibble ≥5 → +3. It is instantiated DIGITS times in a generate loop.
- The FSM, counter, pending logic and output register live in bin_bcd_seq.

## Test plan
- After reset, AUTO_START=0, start_i pulse with bin_i=0 → done_o pulse 14 cycles later, bcd_o=0x0000, busy_o high for 13 cycles.
- bin_i=8191 and start → bcd_o=0x8191. bin_i=1234 → 0x1234. bcd_o holds 0x8191 for the entire second conversion.
- Start with 42. During SHIFT, request 7 and then 100 → results 0x0042, then 0x0100 only, with no 0x0007. The second done_o comes 14 cycles after the first.
- Request asserted in the DONE cycle of conversion 5 with bin_i=6 → next SHIFT follows immediately; bcd_o=0x0006 14 cycles after the first done_o.
- rst_i pulsed mid-SHIFT at iteration 6 of bin_i=999 → bcd_o=0, busy_o=0, no done_o. After release with start → 0x0999.
- AUTO_START=1: bin_i steps 0→15→15→300 → exactly two conversions, results 0x0015 then 0x0300. A constant bin_i produces no further done_o.
